alu_issue_ctrl: RTL and testbench

- Sequential issue/writeback stage wrapped around the combinational 3-bit-opcode ALU (ops 0 add, 1 sub, 2 and, 3 or, 4 logical shift right, 5 arithmetic shift right).
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x32 register file.
- Drives the ALU inputs from registers, captures the result, writes it back, and returns it over a second valid/ready handshake.
- The ALU is external and instantiated beside this block; this block is its direct upstream and downstream.

---
 rtl/alu_issue_ctrl_if.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundles the instruction channel, the ALU operand/result bus, the result
// channel and the debug/status taps of alu_issue_ctrl.
interface alu_issue_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      instr;
   logic [31:0]      alu_A;
   logic [31:0]      alu_B;
   logic [2:0]       alu_op;
   logic [31:0]      alu_C;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [2:0]       out_rd;
   logic             out_err;
   logic [2:0]       dbg_addr;
   logic [31:0]      dbg_data;
   logic [CNT_W-1:0] retired;

   modport slave (
      input  in_valid, instr, alu_C, out_ready, dbg_addr,
      output in_ready, alu_A, alu_B, alu_op, out_valid, out_data, out_rd,
             out_err, dbg_data, retired
   );

   modport master (
      output in_valid, instr, alu_C, out_ready, dbg_addr,
      input  in_ready, alu_A, alu_B, alu_op, out_valid, out_data, out_rd,
             out_err, dbg_data, retired
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around an external combinational ALU: one instruction
// in flight at a time, IDLE -> EXEC -> RESP, with an 8x32 register file.
module alu_issue_ctrl #(
   parameter int NREG  = 8,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              reset,
   alu_issue_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic             in_ready_r;
   logic             out_valid_r;
   logic [31:0]      rf_r [NREG];
   logic [2:0]       rd_r;
   logic [31:0]      alu_a_r;
   logic [31:0]      alu_b_r;
   logic [2:0]       alu_op_r;
   logic [31:0]      out_data_r;
   logic [2:0]       out_rd_r;
   logic             out_err_r;
   logic [CNT_W-1:0] retired_r;

   logic [2:0]       op_s;
   logic [2:0]       rd_s;
   logic [2:0]       rs_s;
   logic             imm_sel_s;
   logic [5:0]       field_s;
   logic             legal_s;
   logic             accept_s;

   // Register 0 is hard-wired to zero on every read port.
   function automatic logic [31:0] rf_read(input logic [2:0] addr);
      if (addr == 3'd0) begin
         return 32'd0;
      end else begin
         return rf_r[addr];
      end
   endfunction

   assign op_s      = bus.instr[15:13];
   assign rd_s      = bus.instr[12:10];
   assign rs_s      = bus.instr[9:7];
   assign imm_sel_s = bus.instr[6];
   assign field_s   = bus.instr[5:0];
   assign legal_s   = (op_s <= 3'd5);
   assign accept_s  = bus.in_valid & in_ready_r;

   // Next-state logic; illegal opcodes skip EXEC and report straight away.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_next_s = legal_s ? EXEC : RESP;
            end else begin
               state_next_s = IDLE;
            end
         end
         EXEC: state_next_s = RESP;
         RESP: begin
            if (bus.out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RESP;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register plus handshake flags registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == IDLE);
         out_valid_r <= (state_next_s == RESP);
      end
   end

   // Operand capture, result capture, writeback and retirement count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            rf_r[i] <= 32'd0;
         end
         rd_r       <= 3'd0;
         alu_a_r    <= 32'd0;
         alu_b_r    <= 32'd0;
         alu_op_r   <= 3'd0;
         out_data_r <= 32'd0;
         out_rd_r   <= 3'd0;
         out_err_r  <= 1'b0;
         retired_r  <= {CNT_W{1'b0}};
      end else begin
         if (state_r == IDLE && accept_s) begin
            rd_r     <= rd_s;
            alu_a_r  <= rf_read(rs_s);
            alu_b_r  <= imm_sel_s ? {26'd0, field_s} : rf_read(field_s[2:0]);
            alu_op_r <= op_s;
            if (!legal_s) begin
               out_err_r  <= 1'b1;
               out_data_r <= 32'd0;
               out_rd_r   <= rd_s;
            end
         end
         if (state_r == EXEC) begin
            out_data_r <= bus.alu_C;
            out_rd_r   <= rd_r;
            out_err_r  <= 1'b0;
            if (rd_r != 3'd0) begin
               rf_r[rd_r] <= bus.alu_C;
            end
         end
         if (state_r == RESP && bus.out_ready) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.alu_A     = alu_a_r;
   assign bus.alu_B     = alu_b_r;
   assign bus.alu_op    = alu_op_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_rd    = out_rd_r;
   assign bus.out_err   = out_err_r;
   assign bus.retired   = retired_r;
   assign bus.dbg_data  = rf_read(bus.dbg_addr);
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a reference ALU closes the loop and
// every observation is compared against hand-computed values.
module tb_alu_issue_ctrl;
   logic clk;
   logic reset;
   int   n_assert;
   int   n_fail;
   int   exp_ret;

   alu_issue_ctrl_if #(.CNT_W(16)) bus ();
   alu_issue_ctrl_if #(.CNT_W(4))  bus2 ();

   alu_issue_ctrl #(.NREG(8), .CNT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   alu_issue_ctrl #(.NREG(8), .CNT_W(4)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a >> b;
         3'd5:    return $signed(a) >>> b;
         default: return 32'd0;
      endcase
   endfunction

   always_comb bus.alu_C  = alu_f(bus.alu_A, bus.alu_B, bus.alu_op);
   always_comb bus2.alu_C = alu_f(bus2.alu_A, bus2.alu_B, bus2.alu_op);

   function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic isel,
                                       input logic [5:0] f6);
      return {op, rd, rs, isel, f6};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_dbg(input logic [2:0] addr, input logic [31:0] exp);
      bus.dbg_addr = addr;
      #1;
      chk($sformatf("dbg_r%0d", addr), bus.dbg_data, exp);
   endtask

   // One instruction end to end; hold > 0 keeps out_ready low for that many extra cycles.
   task automatic do_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic isel, input logic [5:0] f6, input logic [31:0] ea,
                        input logic [31:0] eb, input logic [31:0] exp, input int hold);
      logic legal;
      legal = (op <= 3'd5);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.instr     = enc(op, rd, rs, isel, f6);
      bus.out_ready = (hold == 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("in_ready_busy", bus.in_ready, 32'd0);
      chk("alu_A", bus.alu_A, ea);
      chk("alu_B", bus.alu_B, eb);
      chk("alu_op", bus.alu_op, {29'd0, op});
      if (legal) begin
         chk("exec_out_valid", bus.out_valid, 32'd0);
         @(negedge clk);
      end
      chk("out_valid", bus.out_valid, 32'd1);
      chk("out_data", bus.out_data, exp);
      chk("out_rd", bus.out_rd, {29'd0, rd});
      chk("out_err", bus.out_err, legal ? 32'd0 : 32'd1);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = i[0];
         bus.instr    = enc(3'd0, 3'd7, 3'd0, 1'b1, 6'd1);
         @(negedge clk);
         chk("hold_out_valid", bus.out_valid, 32'd1);
         chk("hold_in_ready", bus.in_ready, 32'd0);
         chk("hold_out_data", bus.out_data, exp);
         chk("hold_out_rd", bus.out_rd, {29'd0, rd});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      exp_ret++;
      chk("done_out_valid", bus.out_valid, 32'd0);
      chk("done_in_ready", bus.in_ready, 32'd1);
      chk("retired", {16'd0, bus.retired}, exp_ret);
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      exp_ret  = 0;
      reset    = 1'b1;
      bus.in_valid   = 1'b0;
      bus.instr      = 16'd0;
      bus.out_ready  = 1'b1;
      bus.dbg_addr   = 3'd0;
      bus2.in_valid  = 1'b0;
      bus2.instr     = 16'd0;
      bus2.out_ready = 1'b1;
      bus2.dbg_addr  = 3'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_in_ready", bus.in_ready, 32'd1);
      chk("rst_out_valid", bus.out_valid, 32'd0);
      chk("rst_retired", {16'd0, bus.retired}, 32'd0);
      chk("rst_alu_A", bus.alu_A, 32'd0);
      chk("rst_alu_B", bus.alu_B, 32'd0);
      chk("rst_alu_op", {29'd0, bus.alu_op}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_rd", {29'd0, bus.out_rd}, 32'd0);
      chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
      chk_dbg(3'd5, 32'd0);

      // Arithmetic, logic and shifts with hand-derived results.
      do_op(3'd0, 3'd1, 3'd0, 1'b1, 6'd5,  32'd0,        32'd5,  32'd5,        0);
      do_op(3'd0, 3'd2, 3'd1, 1'b1, 6'd7,  32'd5,        32'd7,  32'd12,       0);
      chk_dbg(3'd2, 32'd12);
      do_op(3'd1, 3'd3, 3'd1, 1'b0, 6'd2,  32'd5,        32'd12, 32'hFFFFFFF9, 0);
      do_op(3'd5, 3'd4, 3'd3, 1'b1, 6'd1,  32'hFFFFFFF9, 32'd1,  32'hFFFFFFFC, 0);
      do_op(3'd4, 3'd5, 3'd3, 1'b1, 6'd1,  32'hFFFFFFF9, 32'd1,  32'h7FFFFFFC, 0);
      do_op(3'd2, 3'd6, 3'd2, 1'b1, 6'd10, 32'd12,       32'd10, 32'd8,        0);
      do_op(3'd3, 3'd7, 3'd2, 1'b1, 6'd10, 32'd12,       32'd10, 32'd14,       0);
      do_op(3'd0, 3'd0, 3'd1, 1'b0, 6'd2,  32'd5,        32'd12, 32'd17,       0);
      chk_dbg(3'd0, 32'd0);
      chk_dbg(3'd4, 32'hFFFFFFFC);
      chk_dbg(3'd5, 32'h7FFFFFFC);
      chk_dbg(3'd7, 32'd14);

      // Illegal opcode: immediate response, no writeback, error clears afterwards.
      do_op(3'd6, 3'd3, 3'd1, 1'b1, 6'd9,  32'd5,        32'd9,  32'd0,        0);
      chk_dbg(3'd3, 32'hFFFFFFF9);
      do_op(3'd0, 3'd1, 3'd1, 1'b1, 6'd1,  32'd5,        32'd1,  32'd6,        0);
      do_op(3'd4, 3'd6, 3'd3, 1'b1, 6'd40, 32'hFFFFFFF9, 32'd40, 32'd0,        0);

      // Backpressure with ignored in_valid pulses.
      do_op(3'd0, 3'd2, 3'd2, 1'b1, 6'd3,  32'd12,       32'd3,  32'd15,       5);
      chk_dbg(3'd7, 32'd14);
      @(negedge clk);
      chk("retired_once", {16'd0, bus.retired}, exp_ret);

      // Reset while in EXEC.
      bus.in_valid = 1'b1;
      bus.instr    = enc(3'd0, 3'd1, 3'd1, 1'b1, 6'd3);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("exec_before_rst", bus.out_valid, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("rst_exec_out_valid", bus.out_valid, 32'd0);
      chk("rst_exec_retired", {16'd0, bus.retired}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_ret = 0;
      chk("post_rst_in_ready", bus.in_ready, 32'd1);
      chk("post_rst_out_valid", bus.out_valid, 32'd0);
      chk_dbg(3'd1, 32'd0);

      // Reset while a result is held in RESP drops out_valid without a clock edge.
      bus.in_valid  = 1'b1;
      bus.instr     = enc(3'd0, 3'd2, 3'd0, 1'b1, 6'd9);
      bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("resp_out_valid", bus.out_valid, 32'd1);
      chk("resp_out_data", bus.out_data, 32'd9);
      #2 reset = 1'b1;
      #1;
      chk("rst_resp_out_valid", bus.out_valid, 32'd0);
      chk_dbg(3'd2, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b1;
      do_op(3'd0, 3'd1, 3'd0, 1'b1, 6'd3,  32'd0,        32'd3,  32'd3,        0);

      // Counter wrap on the narrow-counter instance.
      bus2.instr = enc(3'd0, 3'd1, 3'd1, 1'b1, 6'd1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bus2.in_valid = 1'b1;
         @(negedge clk);
         bus2.in_valid = 1'b0;
         @(negedge clk);
         @(negedge clk);
         if (i == 14) chk("wrap_retired_15", {28'd0, bus2.retired}, 32'd15);
      end
      chk("wrap_retired_0", {28'd0, bus2.retired}, 32'd0);
      bus2.dbg_addr = 3'd1;
      #1;
      chk("wrap_r1", bus2.dbg_data, 32'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
